// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. Two WIDTH-bit operands are combined
//   DIGIT_W bits per clock, starting from the least significant digit.
//   A start/busy/done handshake frames each operation. The result is
//   registered and held until the next completion.
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous, active-high reset
//   start    : operation request, sampled on the rising edge of clk
//   sub      : 0 = a + b + cin, 1 = a - b (captured with start)
//   cin      : carry-in for add, ignored for subtract
//   a, b     : WIDTH-bit operands (captured with start)
//   busy     : high while an operation is in progress
//   done     : one-cycle pulse when sum/cout/overflow are updated
//   sum      : registered WIDTH-bit result
//   cout     : carry out of the MSB (for subtract, 1 = no borrow)
//   overflow : two's-complement signed overflow
module serial_adder #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               c_r;
  logic [WIDTH-1:0]   res_r;
  logic [CW-1:0]      cnt_r;

  logic [DIGIT_W+1:0] dres_s;
  logic [DIGIT_W-1:0] dsum_s;
  logic               dcmsb_s;
  logic               dcout_s;
  logic [WIDTH-1:0]   res_next_s;
  logic               last_s;

  // Ripple of DIGIT_W full-adder cells.
  // Returns {carry_out, carry_into_top_bit, digit_sum}.
  function automatic logic [DIGIT_W+1:0] digit_add(
    input logic [DIGIT_W-1:0] x,
    input logic [DIGIT_W-1:0] y,
    input logic               c
  );
    logic [DIGIT_W-1:0] s;
    logic               carry;
    logic               c_top;
    s     = {DIGIT_W{1'b0}};
    carry = c;
    c_top = 1'b0;
    for (int i = 0; i < DIGIT_W; i++) begin
      if (i == DIGIT_W - 1) begin
        c_top = carry;
      end else begin
        c_top = c_top;
      end
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (x[i] & carry) | (y[i] & carry);
    end
    return {carry, c_top, s};
  endfunction

  // Current digit arithmetic and the next value of the result shift register.
  always_comb begin
    dres_s  = digit_add(a_r[DIGIT_W-1:0], b_r[DIGIT_W-1:0], c_r);
    dsum_s  = dres_s[DIGIT_W-1:0];
    dcmsb_s = dres_s[DIGIT_W];
    dcout_s = dres_s[DIGIT_W+1];
    // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
    res_next_s = (WIDTH'(dsum_s) << (WIDTH - DIGIT_W)) | (res_r >> DIGIT_W);
    last_s     = (cnt_r == CW'(N - 1));
  end

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      c_r      <= 1'b0;
      res_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= {WIDTH{1'b0}};
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        // DONE behaves like IDLE for a new request, giving back-to-back operation.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            // Subtract as a + ~b + 1.
            b_r     <= sub ? ~b : b;
            c_r     <= sub ? 1'b1 : cin;
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT_W;
          b_r   <= b_r >> DIGIT_W;
          c_r   <= dcout_s;
          res_r <= res_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            sum      <= res_next_s;
            cout     <= dcout_s;
            // Signed overflow: carry into MSB differs from carry out of MSB.
            overflow <= dcmsb_s ^ dcout_s;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= DONE;
          end else begin
            state_r  <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder. Two instances share operands and
//   reset: u_d1 (WIDTH=8, DIGIT_W=1, 8 RUN cycles) and u_d4 (WIDTH=8,
//   DIGIT_W=4, 2 RUN cycles). Expected values are hand-computed constants.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;

  logic       start1;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;

  logic       start4;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .DIGIT_W(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .overflow(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT_W(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy4), .done(done4), .sum(sum4),
    .cout(cout4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on the DIGIT_W=1 instance; checks busy/done each cycle.
  task automatic run1(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic sv, input logic cv, input logic [7:0] es,
                      input logic ec, input logic eo);
    @(negedge clk);
    a = av; b = bv; sub = sv; cin = cv; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    // Scramble inputs after capture; result must not change.
    a = ~av; b = ~bv; sub = ~sv; cin = ~cv;
    check({tag, "_busy_c0"}, {31'd0, busy1}, 32'd1);
    check({tag, "_done_c0"}, {31'd0, done1}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      check({tag, "_busy_run"}, {31'd0, busy1}, 32'd1);
      check({tag, "_done_run"}, {31'd0, done1}, 32'd0);
    end
    @(posedge clk); #1;
    check({tag, "_done"}, {31'd0, done1}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy1}, 32'd0);
    check({tag, "_sum"}, {24'd0, sum1}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout1}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf1}, {31'd0, eo});
    @(posedge clk); #1;
    check({tag, "_done_clr"}, {31'd0, done1}, 32'd0);
    check({tag, "_sum_hold"}, {24'd0, sum1}, {24'd0, es});
  endtask

  initial begin
    int dcount;
    int dcycle;
    logic [7:0] dsum;
    logic       dovf;

    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_done1", {31'd0, done1}, 32'd0);
    check("rst_sum1", {24'd0, sum1}, 32'd0);
    check("rst_cout1", {31'd0, cout1}, 32'd0);
    check("rst_ovf1", {31'd0, ovf1}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_sum4", {24'd0, sum4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Additions and subtractions, DIGIT_W=1
    run1("add_0f_01",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run1("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run1("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run1("add_ff_00c",  8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    run1("sub_05_07",   8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    run1("sub_80_01",   8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    run1("sub_80_01c",  8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // DIGIT_W=4: add 3C+4D, start held high through DONE for a second op
    @(negedge clk);
    a = 8'h3C; b = 8'h4D; sub = 1'b0; cin = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;                       // edge k
    check("d4_busy_k", {31'd0, busy4}, 32'd1);
    a = 8'h10; b = 8'h20; sub = 1'b1; cin = 1'b0;  // second op: 10-20
    @(posedge clk); #1;                       // k+1, start ignored in RUN
    check("d4_busy_k1", {31'd0, busy4}, 32'd1);
    check("d4_done_k1", {31'd0, done4}, 32'd0);
    @(posedge clk); #1;                       // k+2, done
    check("d4_done", {31'd0, done4}, 32'd1);
    check("d4_busy_done", {31'd0, busy4}, 32'd0);
    check("d4_sum", {24'd0, sum4}, 32'h89);
    check("d4_cout", {31'd0, cout4}, 32'd0);
    check("d4_ovf", {31'd0, ovf4}, 32'd1);
    @(posedge clk); #1;                       // k+3, accepted from DONE
    start4 = 1'b0;
    check("d4_b2b_busy", {31'd0, busy4}, 32'd1);
    check("d4_b2b_done", {31'd0, done4}, 32'd0);
    check("d4_b2b_hold", {24'd0, sum4}, 32'h89);
    @(posedge clk); #1;
    check("d4_b2b_busy2", {31'd0, busy4}, 32'd1);
    @(posedge clk); #1;
    check("d4_b2b_done2", {31'd0, done4}, 32'd1);
    check("d4_b2b_sum", {24'd0, sum4}, 32'hF0);
    check("d4_b2b_cout", {31'd0, cout4}, 32'd0);
    check("d4_b2b_ovf", {31'd0, ovf4}, 32'd0);
    @(posedge clk); #1;
    check("d4_idle_done", {31'd0, done4}, 32'd0);
    check("d4_idle_busy", {31'd0, busy4}, 32'd0);

    // Start pulse 3 cycles into RUN is ignored: 7F+7F=FE, ovf
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    dcount = 0; dcycle = 0; dsum = 8'h00; dovf = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) begin
        a = 8'h01; b = 8'h02; sub = 1'b1; cin = 1'b1; start1 = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      @(posedge clk); #1;
      if (done1) begin
        dcount++; dcycle = i; dsum = sum1; dovf = ovf1;
      end
    end
    start1 = 1'b0;
    check("ign_done_count", dcount, 32'd1);
    check("ign_done_cycle", dcycle, 32'd8);
    check("ign_sum", {24'd0, dsum}, 32'hFE);
    check("ign_ovf", {31'd0, dovf}, 32'd1);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    a = 8'h55; b = 8'h22; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy1}, 32'd0);
    check("arst_done", {31'd0, done1}, 32'd0);
    check("arst_sum", {24'd0, sum1}, 32'd0);
    check("arst_cout", {31'd0, cout1}, 32'd0);
    check("arst_ovf", {31'd0, ovf1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) dcount++;
    end
    check("arst_no_done", dcount, 32'd0);
    run1("post_rst_add", 8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor; the sequential successor to the team's single-bit half-adder cell.
- Adds or subtracts two WIDTH-bit operands DIGIT_W bits per clock, starting from the LSB digit.
- Uses a start/busy/done handshake and holds a registered result.
- Used where area matters more than latency, e.g. accumulate paths in the lab datapath exercises.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT_W, 1, bits processed per RUN cycle; WIDTH must be an integer multiple of DIGIT_W.
- N (localparam), WIDTH/DIGIT_W, number of RUN cycles.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request; sampled on the rising edge of clk.
- sub  input  1  0 = add, 1 = subtract (a − b); captured with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while operation in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow (a ≥ b unsigned).
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- On rst: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0; internal shift registers and counter cleared. This applies immediately, including mid-operation; the aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k → capture A=a, B = sub ? ~b : b, C = sub ? 1 : cin; counter=0; go to RUN; busy=1 after edge k.
- RUN: each edge adds the low DIGIT_W bits of A and B plus C (ripple of full-adder cells).
  - The digit result is shifted in at the top of the result shift register.
  - A and B are shifted right by DIGIT_W; C takes the digit carry-out; counter increments.
  - The carry into bit DIGIT_W−1 of the final digit is retained as cmsb.
- The last digit is processed at edge k+N. At that edge:
  - sum ← full result; cout ← final carry; overflow ← cmsb XOR final carry.
  - busy ← 0, done ← 1; state → DONE.
  - Total latency from start edge to done is N cycles.
- DONE: lasts exactly one cycle; done=1. At the next edge: done ← 0 and state → IDLE. If start=1 at that edge, it is accepted as if in IDLE (back-to-back operation; busy=1, done=0 after that edge).
- start while in RUN is ignored; inputs are not re-captured.
- a, b, sub and cin may change freely after the capture edge without affecting the result.
- sum, cout and overflow are updated only at completion and hold their value until the next completion or reset. They are not modified during RUN.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, DIGIT_W=1: add a=0x0F, b=0x01, cin=0 → done exactly 8 cycles after the start edge; sum=0x10, cout=0, overflow=0; busy high for 8 cycles.
- Add a=0x7F, b=0x01 → sum=0x80, cout=0, overflow=1. Add a=0xFF, b=0x01 → sum=0x00, cout=1, overflow=0. Add a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- Subtract a=0x05, b=0x07 → sum=0xFE, cout=0, overflow=0. Subtract a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1. Subtract with cin=1 gives an identical result (cin ignored).
- WIDTH=8, DIGIT_W=4: add a=0x3C, b=0x4D → done 2 cycles after start; sum=0x89, cout=0, overflow=1. Then start held high during DONE → second operation accepted with no idle cycle.
- Pulse start again 3 cycles into a RUN with different operands → ignored; first result correct, done pulses once.
- Assert rst mid-RUN (asynchronous, between edges) → busy, done, sum, cout and overflow are 0 immediately; no done after rst deasserts; a fresh start then completes correctly.
